// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use hazard and taken-branch pipeline control.
// Holds the PC and IF/ID and bubbles ID/EX for LOAD_LAT cycles per load-use
// hazard. A taken branch flushes IF/ID and bubbles ID/EX, and it wins over a
// hazard. Control outputs are combinational from state and inputs.
// Optional feature macro: HAZARD_PERF_EN (saturating stall/flush counters).
// Without it, stall_count and flush_count are tied to zero.
// o_dbg_state exposes the FSM state (0 = RUN, 1 = STALL) for observation.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memtoreg,
    input  logic        ex_reg_en,
    input  logic        ex_br_taken,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
    output logic        o_dbg_state
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Down-counter start value after the first bubble cycle spent in RUN.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_hazard;
    logic       w_pc_stall;
    logic       w_if_id_stall;
    logic       w_if_id_flush;
    logic       w_id_ex_bubble;

    // A load in EX writing a non-x0 register that ID reads is a load-use hazard.
    assign w_hazard = id_valid & ex_memtoreg & ex_reg_en & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

    // State and stall counter register; reset abandons any pending stall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and control outputs; outputs are held low while in reset.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        if (reset) begin
            case (r_state)
                ST_RUN: begin
                    if (ex_br_taken) begin
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end else if (w_hazard) begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = ST_STALL;
                            w_cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    if (ex_br_taken) begin
                        // The branch squashes the stalled instruction anyway.
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                        w_state_nxt    = ST_RUN;
                        w_cnt_nxt      = 3'd0;
                    end else begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                        if (r_cnt <= 3'd1) begin
                            w_state_nxt = ST_RUN;
                            w_cnt_nxt   = 3'd0;
                        end else begin
                            w_cnt_nxt   = r_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    assign pc_stall     = w_pc_stall;
    assign if_id_stall  = w_if_id_stall;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_bubble = w_id_ex_bubble;
    assign o_dbg_state  = r_state;

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            if (w_pc_stall && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
            if (w_if_id_flush && (r_flush_count != 16'hFFFF))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    assign stall_count = 16'd0;
    assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LOAD_LAT 1, 3, 4) share
// the stimulus. Inputs change 1 time unit after a rising edge and outputs
// are checked 1 time unit later. Control vectors are
// {pc_stall, if_id_stall, if_id_flush, id_ex_bubble}.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [3:0] C_IDLE  = 4'b0000;
    localparam logic [3:0] C_STALL = 4'b1101;
    localparam logic [3:0] C_FLUSH = 4'b0011;

    logic clock = 1'b0;
    logic reset;
    logic id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic ex_memtoreg, ex_reg_en, ex_br_taken;

    logic pcs1, ifs1, iff1, bub1, st1;
    logic pcs3, ifs3, iff3, bub3, st3;
    logic pcs4, ifs4, iff4, bub4, st4;
    logic [15:0] sc1, fc1, sc3, fc3, sc4, fc4;
    logic [3:0] ctl1, ctl3, ctl4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hazard_ctrl #(.LOAD_LAT(1)) u1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_memtoreg(ex_memtoreg), .ex_reg_en(ex_reg_en),
        .ex_br_taken(ex_br_taken), .pc_stall(pcs1), .if_id_stall(ifs1),
        .if_id_flush(iff1), .id_ex_bubble(bub1), .stall_count(sc1),
        .flush_count(fc1), .o_dbg_state(st1));

    hazard_ctrl #(.LOAD_LAT(3)) u3 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_memtoreg(ex_memtoreg), .ex_reg_en(ex_reg_en),
        .ex_br_taken(ex_br_taken), .pc_stall(pcs3), .if_id_stall(ifs3),
        .if_id_flush(iff3), .id_ex_bubble(bub3), .stall_count(sc3),
        .flush_count(fc3), .o_dbg_state(st3));

    hazard_ctrl #(.LOAD_LAT(4)) u4 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_memtoreg(ex_memtoreg), .ex_reg_en(ex_reg_en),
        .ex_br_taken(ex_br_taken), .pc_stall(pcs4), .if_id_stall(ifs4),
        .if_id_flush(iff4), .id_ex_bubble(bub4), .stall_count(sc4),
        .flush_count(fc4), .o_dbg_state(st4));

    assign ctl1 = {pcs1, ifs1, iff1, bub1};
    assign ctl3 = {pcs3, ifs3, iff3, bub3};
    assign ctl4 = {pcs4, ifs4, iff4, bub4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [3:0] e1, input logic [3:0] e3,
                           input logic [3:0] e4);
        chk({tag, "_ctl1"}, 32'(ctl1), 32'(e1));
        chk({tag, "_ctl3"}, 32'(ctl3), 32'(e3));
        chk({tag, "_ctl4"}, 32'(ctl4), 32'(e4));
    endtask

    task automatic chk_cnt(input string tag, input int s1, input int s3, input int s4,
                           input int f);
        chk({tag, "_sc1"}, 32'(sc1), PERF ? s1 : 0);
        chk({tag, "_sc3"}, 32'(sc3), PERF ? s3 : 0);
        chk({tag, "_sc4"}, 32'(sc4), PERF ? s4 : 0);
        chk({tag, "_fc1"}, 32'(fc1), PERF ? f : 0);
        chk({tag, "_fc3"}, 32'(fc3), PERF ? f : 0);
        chk({tag, "_fc4"}, 32'(fc4), PERF ? f : 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_memtoreg = 1'b0; ex_reg_en = 1'b0; ex_br_taken = 1'b0;
    endtask

    // Load into x5 in EX, ID reads x5 through rs1.
    task automatic hazard_rs1();
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        id_rs2 = 5'd9; id_rs2_used = 1'b0;
        ex_rd = 5'd5; ex_memtoreg = 1'b1; ex_reg_en = 1'b1; ex_br_taken = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset: outputs forced low even with a hazard present.
        reset = 1'b0;
        idle();
        tick(); tick();
        #1;
        chk_ctl("rst_idle", C_IDLE, C_IDLE, C_IDLE);
        chk_cnt("rst", 0, 0, 0, 0);
        chk("rst_state4", 32'(st4), 0);
        hazard_rs1();
        #1;
        chk_ctl("rst_forced", C_IDLE, C_IDLE, C_IDLE);
        tick();
        reset = 1'b1;
        idle();
        tick();

        // Test 1/2: one-cycle hazard, then EX bubbled.
        hazard_rs1();
        #1;
        chk_ctl("t1_c0", C_STALL, C_STALL, C_STALL);
        tick();
        idle();
        #1;
        chk_ctl("t1_c1", C_IDLE, C_STALL, C_STALL);
        chk("t1_st3_c1", 32'(st3), 1);
        chk("t1_sc1", 32'(sc1), PERF ? 1 : 0);
        tick();
        #1;
        chk_ctl("t2_c2", C_IDLE, C_STALL, C_STALL);
        tick();
        #1;
        chk_ctl("t2_c3", C_IDLE, C_IDLE, C_STALL);
        chk("t2_st3_run", 32'(st3), 0);
        tick();
        #1;
        chk_ctl("t2_c4", C_IDLE, C_IDLE, C_IDLE);
        chk("t2_st4_run", 32'(st4), 0);
        chk_cnt("t2", 1, 3, 4, 0);

        // Test 3: x0 load, unused rs2 match, id_valid low: no stall.
        ex_memtoreg = 1'b1; ex_reg_en = 1'b1; ex_rd = 5'd0;
        id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        #1;
        chk_ctl("t3_x0", C_IDLE, C_IDLE, C_IDLE);
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs2_used = 1'b0;
        #1;
        chk_ctl("t3_rs2_unused", C_IDLE, C_IDLE, C_IDLE);
        id_rs2_used = 1'b1; id_valid = 1'b0;
        #1;
        chk_ctl("t3_invalid", C_IDLE, C_IDLE, C_IDLE);
        ex_reg_en = 1'b0; id_valid = 1'b1;
        #1;
        chk_ctl("t3_no_regen", C_IDLE, C_IDLE, C_IDLE);
        ex_reg_en = 1'b1;
        #1;
        chk_ctl("t3_rs2_hit", C_STALL, C_STALL, C_STALL);
        tick();
        idle();
        tick(); tick(); tick();
        #1;
        chk_ctl("t3_drain", C_IDLE, C_IDLE, C_IDLE);
        chk_cnt("t3", 2, 6, 8, 0);

        // Test 4: hazard and taken branch together; branch wins.
        hazard_rs1();
        ex_br_taken = 1'b1;
        #1;
        chk_ctl("t4_both", C_FLUSH, C_FLUSH, C_FLUSH);
        tick();
        idle();
        #1;
        chk_ctl("t4_after", C_IDLE, C_IDLE, C_IDLE);
        chk_cnt("t4", 2, 6, 8, 1);

        // Branch arriving during STALL cancels the remaining stall.
        hazard_rs1();
        tick();
        idle();
        ex_br_taken = 1'b1;
        #1;
        chk_ctl("t4b_br", C_FLUSH, C_FLUSH, C_FLUSH);
        tick();
        idle();
        #1;
        chk_ctl("t4b_after", C_IDLE, C_IDLE, C_IDLE);
        chk("t4b_st3", 32'(st3), 0);
        chk("t4b_st4", 32'(st4), 0);
        chk_cnt("t4b", 3, 7, 9, 2);

        // Test 5: reset during the 2nd STALL cycle of LOAD_LAT=4.
        hazard_rs1();
        tick();
        idle();
        #1;
        chk("t5_stall2", 32'(ctl4), 32'(C_STALL));
        reset = 1'b0;
        #1;
        chk_ctl("t5_rst_now", C_IDLE, C_IDLE, C_IDLE);
        tick();
        #1;
        chk_ctl("t5_rst_next", C_IDLE, C_IDLE, C_IDLE);
        chk("t5_st4", 32'(st4), 0);
        chk_cnt("t5", 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        #1;
        chk_ctl("t5_rel1", C_IDLE, C_IDLE, C_IDLE);
        tick();
        #1;
        chk_ctl("t5_rel2", C_IDLE, C_IDLE, C_IDLE);
        chk("t5_st4_rel", 32'(st4), 0);

`ifdef HAZARD_PERF_EN
        // Test 6: sustained hazard saturates the stall counter.
        hazard_rs1();
        repeat (70000) tick();
        #1;
        chk("t6_sc1_sat", 32'(sc1), 32'hFFFF);
        chk("t6_sc4_sat", 32'(sc4), 32'hFFFF);
        tick();
        #1;
        chk("t6_sc1_hold", 32'(sc1), 32'hFFFF);
        idle();
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
